// File: rtl/multi_stage_issue_arbiter.sv
// multi_stage_issue_arbiter
// Round-robin issue arbiter in front of the shared pipelined multi-cycle
// arithmetic unit. It grants one strand per cycle, tracks the owner,
// destination and opcode of each op alongside the unit's pipeline, and
// flags the writeback in the cycle the unit's unregistered result is valid.
// Each strand may have only one op in flight. A per-strand flush drops
// that strand's in-flight entries.

module multi_stage_issue_arbiter #(
  parameter int NUM_STRANDS = 4,
  parameter int LATENCY     = 3,
  parameter int OP_WIDTH    = 6,
  localparam int SW         = $clog2(NUM_STRANDS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_STRANDS-1:0]          req,
  input  logic [NUM_STRANDS*OP_WIDTH-1:0] req_op,
  input  logic [NUM_STRANDS*5-1:0]        req_dest,
  input  logic [NUM_STRANDS-1:0]          flush,
  output logic [NUM_STRANDS-1:0]          grant,
  output logic [OP_WIDTH-1:0]             issue_op,
  output logic [SW-1:0]                   issue_strand,
  output logic [NUM_STRANDS-1:0]          strand_busy,
  output logic                            wb_valid,
  output logic [SW-1:0]                   wb_strand,
  output logic [4:0]                      wb_dest,
  output logic [OP_WIDTH-1:0]             wb_op
);

  localparam logic [NUM_STRANDS-1:0] ONE_HOT0 = {{(NUM_STRANDS-1){1'b0}}, 1'b1};

  logic [NUM_STRANDS-1:0] elig_s;
  logic [NUM_STRANDS-1:0] grant_s;
  logic [NUM_STRANDS-1:0] wb_clear_s;
  logic [NUM_STRANDS-1:0] busy_r;
  logic [SW-1:0]          ptr_r;
  logic [SW-1:0]          pick_s;
  logic                   found_s;
  logic [OP_WIDTH-1:0]    op_s;
  logic [4:0]             dest_s;

  // Tracking stages; index LATENCY-1 lines up with the unit's result.
  logic                   stg_valid_r  [LATENCY];
  logic [SW-1:0]          stg_strand_r [LATENCY];
  logic [4:0]             stg_dest_r   [LATENCY];
  logic [OP_WIDTH-1:0]    stg_op_r     [LATENCY];

  // Round-robin pick among eligible strands, searching upward from the pointer.
  // Eligibility is also gated by reset, so grant drops as soon as reset asserts.
  always_comb begin
    logic [SW-1:0] idx;
    idx     = {SW{1'b0}};
    elig_s  = req & ~busy_r & ~flush & {NUM_STRANDS{~reset}};
    found_s = 1'b0;
    pick_s  = {SW{1'b0}};
    for (int off = 0; off < NUM_STRANDS; off++) begin
      // The pointer wraps naturally because NUM_STRANDS is a power of two.
      idx = ptr_r + SW'(off);
      if (!found_s && elig_s[idx]) begin
        found_s = 1'b1;
        pick_s  = idx;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Grant vector and the opcode and destination of the selected strand.
  // Opcode and destination are zero when nothing is granted.
  always_comb begin
    if (found_s) begin
      grant_s = ONE_HOT0 << pick_s;
      op_s    = req_op[pick_s*OP_WIDTH +: OP_WIDTH];
      dest_s  = req_dest[pick_s*5 +: 5];
    end else begin
      grant_s = {NUM_STRANDS{1'b0}};
      op_s    = {OP_WIDTH{1'b0}};
      dest_s  = 5'd0;
    end
  end

  // Busy bit of the strand whose result is in writeback this cycle.
  always_comb begin
    if (stg_valid_r[LATENCY-1]) begin
      wb_clear_s = ONE_HOT0 << stg_strand_r[LATENCY-1];
    end else begin
      wb_clear_s = {NUM_STRANDS{1'b0}};
    end
  end

  // Round-robin pointer: moves past the granted strand and holds when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r <= {SW{1'b0}};
    end else if (found_s) begin
      ptr_r <= pick_s + SW'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Busy is set by a grant and cleared by writeback or flush.
  // A strand cannot be granted while busy or flushed, so set and clear never
  // apply to the same strand in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r <= {NUM_STRANDS{1'b0}};
    end else begin
      busy_r <= (busy_r & ~wb_clear_s & ~flush) | grant_s;
    end
  end

  // Tracking pipeline: it never stalls. A flush kills the owner's entries as
  // they move to the next stage. The last stage is not killed, because its
  // writeback is already visible in the flush cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < LATENCY; j++) begin
        stg_valid_r[j]  <= 1'b0;
        stg_strand_r[j] <= {SW{1'b0}};
        stg_dest_r[j]   <= 5'd0;
        stg_op_r[j]     <= {OP_WIDTH{1'b0}};
      end
    end else begin
      stg_valid_r[0]  <= found_s;
      stg_strand_r[0] <= pick_s;
      stg_dest_r[0]   <= dest_s;
      stg_op_r[0]     <= op_s;
      for (int j = 1; j < LATENCY; j++) begin
        stg_valid_r[j]  <= stg_valid_r[j-1] && !flush[stg_strand_r[j-1]];
        stg_strand_r[j] <= stg_strand_r[j-1];
        stg_dest_r[j]   <= stg_dest_r[j-1];
        stg_op_r[j]     <= stg_op_r[j-1];
      end
    end
  end

  assign grant        = grant_s;
  assign issue_op     = op_s;
  assign issue_strand = pick_s;
  assign strand_busy  = busy_r;
  assign wb_valid     = stg_valid_r[LATENCY-1];
  assign wb_strand    = stg_strand_r[LATENCY-1];
  assign wb_dest      = stg_dest_r[LATENCY-1];
  assign wb_op        = stg_op_r[LATENCY-1];

endmodule

// File: tb/tb_multi_stage_issue_arbiter.sv
// Self-checking bench for multi_stage_issue_arbiter: directed scenarios and
// random traffic, checked against a transaction-level model. The model keeps
// a list of in-flight ops, each with its due writeback cycle.

module tb_multi_stage_issue_arbiter;

  localparam int N   = 4;
  localparam int OPW = 6;
  localparam int SW  = 2;
  localparam int LAT = 3;

  logic               clk = 1'b0;
  logic               reset;
  logic [N-1:0]       req;
  logic [N*OPW-1:0]   req_op;
  logic [N*5-1:0]     req_dest;
  logic [N-1:0]       flush;
  logic [N-1:0]       grant;
  logic [OPW-1:0]     issue_op;
  logic [SW-1:0]      issue_strand;
  logic [N-1:0]       strand_busy;
  logic               wb_valid;
  logic [SW-1:0]      wb_strand;
  logic [4:0]         wb_dest;
  logic [OPW-1:0]     wb_op;

  multi_stage_issue_arbiter #(.NUM_STRANDS(N), .LATENCY(LAT), .OP_WIDTH(OPW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_op(req_op), .req_dest(req_dest),
    .flush(flush), .grant(grant), .issue_op(issue_op), .issue_strand(issue_strand),
    .strand_busy(strand_busy), .wb_valid(wb_valid), .wb_strand(wb_strand),
    .wb_dest(wb_dest), .wb_op(wb_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    int strand;
    int dest;
    int op;
    int due;
  } entry_t;

  entry_t inflight[$];
  bit     m_busy[N];
  int     m_ptr;
  int     cyc;
  int     n_vec = 0;
  int     n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    inflight.delete();
    for (int s = 0; s < N; s++) m_busy[s] = 1'b0;
    m_ptr = 0;
  endtask

  // One clock cycle: drive inputs, check at negedge, then advance the model at the edge.
  task automatic step(input logic [N-1:0] r, input logic [N*OPW-1:0] o,
                      input logic [N*5-1:0] d, input logic [N-1:0] f);
    int g;
    int wbi;
    int s;
    logic [N-1:0] exp_grant;
    logic [N-1:0] exp_busy;
    req = r; req_op = o; req_dest = d; flush = f;
    @(negedge clk);
    g = -1;
    for (int off = 0; off < N; off++) begin
      s = (m_ptr + off) % N;
      if (g < 0 && r[s] && !m_busy[s] && !f[s]) g = s;
    end
    wbi = -1;
    for (int k = 0; k < inflight.size(); k++)
      if (inflight[k].due == cyc) wbi = k;
    exp_grant = '0;
    if (g >= 0) exp_grant[g] = 1'b1;
    for (int k = 0; k < N; k++) exp_busy[k] = m_busy[k];
    check_val("grant", 32'(grant), 32'(exp_grant));
    check_val("issue_op", 32'(issue_op), (g >= 0) ? 32'(o[g*OPW +: OPW]) : 32'd0);
    check_val("issue_strand", 32'(issue_strand), (g >= 0) ? 32'(g) : 32'd0);
    check_val("strand_busy", 32'(strand_busy), 32'(exp_busy));
    check_val("wb_valid", 32'(wb_valid), (wbi >= 0) ? 32'd1 : 32'd0);
    if (wbi >= 0) begin
      check_val("wb_strand", 32'(wb_strand), 32'(inflight[wbi].strand));
      check_val("wb_dest", 32'(wb_dest), 32'(inflight[wbi].dest));
      check_val("wb_op", 32'(wb_op), 32'(inflight[wbi].op));
    end
    @(posedge clk);
    if (wbi >= 0) begin
      m_busy[inflight[wbi].strand] = 1'b0;
      inflight.delete(wbi);
    end
    for (int k = inflight.size() - 1; k >= 0; k--)
      if (f[inflight[k].strand]) inflight.delete(k);
    for (int k = 0; k < N; k++)
      if (f[k]) m_busy[k] = 1'b0;
    if (g >= 0) begin
      inflight.push_back('{strand: g, dest: int'(d[g*5 +: 5]), op: int'(o[g*OPW +: OPW]), due: cyc + LAT});
      m_busy[g] = 1'b1;
      m_ptr = (g + 1) % N;
    end
    cyc++;
    #1;
  endtask

  // Reset pulse inside a cycle, with requests held high.
  task automatic async_reset_mid(input logic [N-1:0] r);
    req = r; flush = '0;
    #1 reset = 1'b1;
    #1;
    check_val("rst_grant", 32'(grant), 32'd0);
    check_val("rst_busy", 32'(strand_busy), 32'd0);
    check_val("rst_wb_valid", 32'(wb_valid), 32'd0);
    check_val("rst_wb_dest", 32'(wb_dest), 32'd0);
    #1 reset = 1'b0;
    model_reset();
  endtask

  logic [N*OPW-1:0] rop;
  logic [N*5-1:0]   rdst;
  logic [N-1:0]     rf;

  initial begin
    reset = 1'b1; req = '0; req_op = '0; req_dest = '0; flush = '0;
    cyc = 0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check_val("init_busy", 32'(strand_busy), 32'd0);
    check_val("init_wb_valid", 32'(wb_valid), 32'd0);
    check_val("init_wb_strand", 32'(wb_strand), 32'd0);
    check_val("init_wb_dest", 32'(wb_dest), 32'd0);
    check_val("init_wb_op", 32'(wb_op), 32'd0);
    check_val("init_grant", 32'(grant), 32'd0);
    reset = 1'b0;

    // Single issue: strand 0 requests FADD into register 7 at cycle 2.
    step('0, '0, '0, '0);
    step('0, '0, '0, '0);
    step(4'b0001, 24'h000001, 20'd7, '0);
    for (int i = 0; i < 5; i++) step('0, '0, '0, '0);

    // Round-robin with all strands requesting continuously.
    rop = 24'h41_0C_83;
    rdst = 20'h3A5C1;
    for (int i = 0; i < 12; i++) step(4'b1111, rop, rdst, '0);
    for (int i = 0; i < 4; i++) step('0, '0, '0, '0);

    // Busy blocking: strand 2 holds its request high.
    for (int i = 0; i < 8; i++) step(4'b0100, 24'h02_4000, 20'h0A000, '0);
    for (int i = 0; i < 4; i++) step('0, '0, '0, '0);

    // Flush mid-flight, then flush and request on the same strand.
    step(4'b0010, 24'h000140, 20'h00060, '0);
    step('0, '0, '0, 4'b0010);
    for (int i = 0; i < 3; i++) step('0, '0, '0, '0);
    step(4'b0010, 24'h000140, 20'h00060, 4'b0010);
    for (int i = 0; i < 4; i++) step('0, '0, '0, '0);

    // Asynchronous reset with three ops in flight.
    for (int i = 0; i < 3; i++) step(4'b1110, 24'h555555, 20'hABCDE, '0);
    async_reset_mid(4'b1111);
    for (int i = 0; i < 6; i++) step(4'b1111, 24'h123456, 20'h13579, '0);

    // Random traffic with occasional flushes and resets.
    for (int i = 0; i < 3000; i++) begin
      rop  = N*OPW'($urandom);
      rdst = N*5'($urandom);
      rf   = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      if ($urandom_range(0, 499) == 0) async_reset_mid(N'($urandom));
      step(N'($urandom), rop, rdst, rf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
